rx_frame_sync_ctrl: RTL
=======================

// Module: rx_frame_sync_ctrl
// PURPOSE
//  Frame-timing scheduler for the Rx CP-removal stage. Takes preamble-correlator peaks
//  (sync_pulse + fractional offset sync_ofs), confirms them, then drives the CP-removal
//  stage's isop/delay_sop once per frame. Flywheels over missed peaks; declares loss of lock.
//  Sits between correlator and interlayer_rmcp; also feeds symbol index to downstream.
// PARAMETERS
//  FRAMESIZE  1056  samples per symbol incl. CP (fftsize+cpsize)
//  N_SYMB     50    symbols per frame; FRAME_LEN = FRAMESIZE*N_SYMB
//  TOL        4     acceptance window half-width, samples (<= 31)
//  CONFIRM_N  3     consecutive in-window peaks needed to lock (>= 2)
//  MISS_MAX   2     consecutive missed peaks before loss of lock (>= 1)
// PORTS
//  clk        in   1  sample clock
//  rst        in   1  asynchronous, active-high reset
//  enable     in   1  0 forces IDLE
//  sync_pulse in   1  correlator peak strobe, 1 cycle
//  sync_ofs   in   6  signed fine offset, valid with sync_pulse
//  isop       out  1  1-cycle frame start to CP-removal stage
//  delay_sop  out  6  signed start offset for CP-removal counter; held between isop
//  symb_idx   out  7  symbol index within frame, 0..N_SYMB-1
//  state      out  2  IDLE=0 SEARCH=1 CONFIRM=2 TRACK=3
//  locked     out  1  1 while state==TRACK
//  lost       out  1  1-cycle pulse on loss of lock
// BEHAVIOUR
//  - Reset (async): all outputs 0, state IDLE, ph/conf/miss counters 0.
//  - ph: phase counter, width $clog2(FRAME_LEN+TOL+1); ph<=0 on accepted peak, else +1.
//    Window: FRAME_LEN-1-TOL <= ph <= FRAME_LEN-1+TOL. Close: ph==FRAME_LEN-1+TOL.
//  - IDLE: enable=1 -> SEARCH next cycle. enable=0 in any state -> IDLE next cycle;
//    isop/locked forced 0, counters cleared, no lost pulse.
//  - SEARCH: any sync_pulse accepted -> CONFIRM, conf=1.
//  - CONFIRM: in-window peak -> conf+1; conf reaching CONFIRM_N -> TRACK, isop.
//    Out-of-window peaks ignored. Window close w/o peak -> SEARCH, conf=0.
//  - TRACK: in-window peak -> isop, delay_sop from sync_ofs, miss=0.
//    Window close w/o peak -> flywheel isop, delay_sop=+TOL, ph<=TOL, miss+1.
//    miss reaching MISS_MAX -> lost pulse, SEARCH, locked=0; no isop that cycle.
//    Out-of-window peaks ignored.
//  - Latency: isop registered, 1 cycle after accepting peak or window close.
//    delay_sop and symb_idx=0 valid in the isop cycle.
//  - Peak exactly on window close counts as in-window; no flywheel.
//  - sync_ofs saturated to [-32,31] (6-bit signed, full range); no wrap.
//  - symb_idx: 0 at isop; +1 every FRAMESIZE cycles after; wraps N_SYMB-1 -> 0.
//    Holds 0 outside TRACK.
// CONFIGURATION
//  OFFSET_AVG_EN defined:
//   - delay_sop on accepted peak = (sum of last 4 accepted sync_ofs + 2) >>> 2.
//   - History (fewer than 4 taps counts missing as 0) cleared on entering SEARCH.
//   - Flywheel neither uses nor updates history.
//  OFFSET_AVG_EN undefined: delay_sop = current sync_ofs.
// TESTING (FRAMESIZE=16 N_SYMB=4 -> FRAME_LEN=64, TOL=2, CONFIRM_N=3, MISS_MAX=2)
//  1. Peaks t=10,74,138 -> state 1,2@11/2@75/3@139; isop+locked@139; symb_idx 1@155, 3@187.
//  2. Locked; next peak at 203 (ph=64, +1 late) -> isop@204, delay_sop=sync_ofs,
//     no flywheel.
//  3. Locked, peaks stop -> flywheel isop at close+1, delay_sop=2. Second miss ->
//     lost=1 one cycle, state=1, locked=0, no isop.
//  4. Locked, stray peak at ph=30 -> ignored: no isop, ph keeps counting, miss unchanged.
//  5. Async rst mid-TRACK -> all outputs 0 immediately, no clock edge needed.
//     enable=0 mid-TRACK -> IDLE next cycle, lost stays 0.
//  6. Accepted ofs 3,4,5,7 -> delay_sop=5 with OFFSET_AVG_EN; 7 without.
//     ofs=-32 -> delay_sop=-32 in both builds.

Source files
------------

// File: rtl/rx_frame_sync_ctrl.sv
// ----------------------------------------------------------------------------
// rx_frame_sync_ctrl
//
// Frame-timing scheduler for the Rx CP-removal stage. Confirms preamble
// correlator peaks, locks onto the frame grid and then issues one isop per
// frame (with the fine start offset delay_sop) to the CP-removal stage.
// While locked, missed peaks are bridged by a flywheel isop. After MISS_MAX
// consecutive misses, lock is dropped and a lost pulse is issued.
//
// Build option:
//   OFFSET_AVG_EN  when defined, delay_sop on an accepted peak is the rounded
//                  mean of the last four accepted sync_ofs values. When
//                  undefined, delay_sop is the current sync_ofs.
//
// Ports:
//   clk        in   sample clock
//   rst        in   asynchronous active-high reset
//   enable     in   0 forces IDLE and clears the counters
//   sync_pulse in   correlator peak strobe (1 cycle)
//   sync_ofs   in   signed fine offset, valid with sync_pulse
//   isop       out  1-cycle frame start strobe
//   delay_sop  out  signed start offset, held between isop strobes
//   symb_idx   out  symbol index within frame (0 outside TRACK)
//   state      out  IDLE=0 SEARCH=1 CONFIRM=2 TRACK=3
//   locked     out  1 while in TRACK
//   lost       out  1-cycle pulse on loss of lock
// ----------------------------------------------------------------------------
module rx_frame_sync_ctrl #(
   parameter int FRAMESIZE = 1056,
   parameter int N_SYMB    = 50,
   parameter int TOL       = 4,
   parameter int CONFIRM_N = 3,
   parameter int MISS_MAX  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              sync_pulse,
   input  logic signed [5:0] sync_ofs,
   output logic              isop,
   output logic signed [5:0] delay_sop,
   output logic [6:0]        symb_idx,
   output logic [1:0]        state,
   output logic              locked,
   output logic              lost
);

   localparam int FRAME_LEN = FRAMESIZE * N_SYMB;
   localparam int PH_W      = $clog2(FRAME_LEN + TOL + 1);
   localparam int CONF_W    = $clog2(CONFIRM_N + 1);
   localparam int MISS_W    = $clog2(MISS_MAX + 1);
   localparam int SC_W      = $clog2(FRAMESIZE + 1);

   localparam logic [PH_W-1:0]   WIN_LO  = PH_W'(FRAME_LEN - 1 - TOL);
   localparam logic [PH_W-1:0]   WIN_HI  = PH_W'(FRAME_LEN - 1 + TOL);
   localparam logic [PH_W-1:0]   PH_TOL  = PH_W'(TOL);
   localparam logic [CONF_W-1:0] CONF_V  = CONF_W'(CONFIRM_N);
   localparam logic [MISS_W-1:0] MISS_V  = MISS_W'(MISS_MAX);
   localparam logic [SC_W-1:0]   SC_LAST = SC_W'(FRAMESIZE - 1);
   localparam logic [6:0]        SI_LAST = 7'(N_SYMB - 1);
   localparam logic signed [5:0] DLY_TOL = 6'(TOL);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEARCH  = 2'd1,
      ST_CONFIRM = 2'd2,
      ST_TRACK   = 2'd3
   } state_t;

   state_t             state_reg, state_next;
   logic [PH_W-1:0]    ph_reg, ph_next;
   logic [CONF_W-1:0]  conf_reg, conf_next;
   logic [MISS_W-1:0]  miss_reg, miss_next;
   logic               isop_reg, isop_next;
   logic               lost_reg, lost_next;
   logic signed [5:0]  dly_reg, dly_next;
   logic [SC_W-1:0]    scnt_reg, scnt_next;
   logic [6:0]         sidx_reg, sidx_next;

   logic               in_win;
   logic               at_close;
   logic               accept;
   logic signed [5:0]  ofs_sel;

   assign in_win   = (ph_reg >= WIN_LO) && (ph_reg <= WIN_HI);
   assign at_close = (ph_reg == WIN_HI);

   // A peak is accepted unconditionally while searching, and only inside
   // the expected window once a frame grid has been established.
   always_comb begin
      accept = 1'b0;
      if (enable && sync_pulse) begin
         case (state_reg)
            ST_SEARCH:             accept = 1'b1;
            ST_CONFIRM, ST_TRACK:  accept = in_win;
            default:               accept = 1'b0;
         endcase
      end
   end

`ifdef OFFSET_AVG_EN
   // Three older accepted offsets; the current sync_ofs is the fourth tap.
   logic [17:0]        hist_reg;
   logic               hist_clr;
   logic signed [5:0]  tap [3];
   logic signed [8:0]  avg_sum;
   logic signed [8:0]  avg_q;

   // History restarts whenever acquisition restarts (SEARCH entry or IDLE).
   assign hist_clr = (state_next == ST_IDLE) ||
                     ((state_next == ST_SEARCH) && (state_reg != ST_SEARCH));

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_tap
         assign tap[gi] = $signed(hist_reg[6*gi +: 6]);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_reg <= '0;
      end else if (hist_clr) begin
         hist_reg <= '0;
      end else if (accept) begin
         hist_reg <= {hist_reg[11:0], sync_ofs};
      end
   end

   // Rounded mean; the arithmetic shift floors, +2 makes it round-half-up.
   assign avg_sum = sync_ofs + tap[0] + tap[1] + tap[2] + 9'sd2;
   assign avg_q   = avg_sum >>> 2;

   always_comb begin
      if (avg_q > 9'sd31)
         ofs_sel = 6'sd31;
      else if (avg_q < -9'sd32)
         ofs_sel = -6'sd32;
      else
         ofs_sel = avg_q[5:0];
   end
`else
   // A 6-bit signed input already spans the full output range.
   assign ofs_sel = sync_ofs;
`endif

   // ------------------------------------------------------------------
   // State register and counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         ph_reg    <= '0;
         conf_reg  <= '0;
         miss_reg  <= '0;
         isop_reg  <= 1'b0;
         lost_reg  <= 1'b0;
         dly_reg   <= '0;
         scnt_reg  <= '0;
         sidx_reg  <= '0;
      end else begin
         state_reg <= state_next;
         ph_reg    <= ph_next;
         conf_reg  <= conf_next;
         miss_reg  <= miss_next;
         isop_reg  <= isop_next;
         lost_reg  <= lost_next;
         dly_reg   <= dly_next;
         scnt_reg  <= scnt_next;
         sidx_reg  <= sidx_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      ph_next    = ph_reg;
      conf_next  = conf_reg;
      miss_next  = miss_reg;
      isop_next  = 1'b0;
      lost_next  = 1'b0;
      dly_next   = dly_reg;

      case (state_reg)
         ST_IDLE: begin
            ph_next    = '0;
            conf_next  = '0;
            miss_next  = '0;
            state_next = ST_SEARCH;
         end

         ST_SEARCH: begin
            // Phase has no meaning until a first peak anchors it.
            ph_next = '0;
            if (accept) begin
               state_next = ST_CONFIRM;
               conf_next  = CONF_W'(1);
            end
         end

         ST_CONFIRM: begin
            if (accept) begin
               ph_next = '0;
               if (conf_reg + CONF_W'(1) == CONF_V) begin
                  state_next = ST_TRACK;
                  conf_next  = '0;
                  miss_next  = '0;
                  isop_next  = 1'b1;
                  dly_next   = ofs_sel;
               end else begin
                  conf_next = conf_reg + CONF_W'(1);
               end
            end else if (at_close) begin
               state_next = ST_SEARCH;
               conf_next  = '0;
               ph_next    = '0;
            end else begin
               ph_next = ph_reg + PH_W'(1);
            end
         end

         ST_TRACK: begin
            // A peak right on the close cycle wins over the flywheel.
            if (accept) begin
               ph_next   = '0;
               miss_next = '0;
               isop_next = 1'b1;
               dly_next  = ofs_sel;
            end else if (at_close) begin
               if (miss_reg + MISS_W'(1) == MISS_V) begin
                  state_next = ST_SEARCH;
                  lost_next  = 1'b1;
                  miss_next  = '0;
                  ph_next    = '0;
               end else begin
                  // Flywheel: the close is TOL samples past the nominal
                  // start, so re-anchor the phase there.
                  isop_next = 1'b1;
                  dly_next  = DLY_TOL;
                  ph_next   = PH_TOL;
                  miss_next = miss_reg + MISS_W'(1);
               end
            end else begin
               ph_next = ph_reg + PH_W'(1);
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (!enable) begin
         state_next = ST_IDLE;
         ph_next    = '0;
         conf_next  = '0;
         miss_next  = '0;
         isop_next  = 1'b0;
         lost_next  = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Symbol index: restarts with every isop, only meaningful in TRACK.
   // ------------------------------------------------------------------
   always_comb begin
      scnt_next = '0;
      sidx_next = '0;
      if (state_next == ST_TRACK && !isop_next) begin
         if (scnt_reg == SC_LAST) begin
            scnt_next = '0;
            sidx_next = (sidx_reg == SI_LAST) ? 7'd0 : sidx_reg + 7'd1;
         end else begin
            scnt_next = scnt_reg + SC_W'(1);
            sidx_next = sidx_reg;
         end
      end
   end

   assign isop      = isop_reg;
   assign lost      = lost_reg;
   assign delay_sop = dly_reg;
   assign symb_idx  = sidx_reg;
   assign state     = state_reg;
   assign locked    = (state_reg == ST_TRACK);

endmodule
